handler_event_scheduler: RTL

- Shares one generated event-handler instance between PORT_COUNT event sources, e.g. several NET_RECV queues feeding one process_packet handler.
- Arbitrates requester events round-robin into the handler's struct input.
- Tracks the originating requester of every in-flight event and routes each handler result back to that requester's output channel.
- The handler returns results strictly in order, one result per accepted event.

---
 rtl/handler_event_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/handler_event_scheduler.sv
// Round-robin event scheduler that shares one in-order handler between
// PORT_COUNT requesters and routes each result back to its originating requester.
module handler_event_scheduler #(
  parameter int PORT_COUNT   = 4,
  parameter int IN_WIDTH     = 32,
  parameter int OUT_WIDTH    = 32,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PORT_COUNT*IN_WIDTH-1:0]        s_event_in_tdata,
  input  logic [PORT_COUNT-1:0]                 s_event_in_tvalid,
  output logic [PORT_COUNT-1:0]                 s_event_in_tready,
  output logic [IN_WIDTH-1:0]                   m_handler_tdata,
  output logic                                  m_handler_tvalid,
  input  logic                                  m_handler_tready,
  input  logic [OUT_WIDTH-1:0]                  s_handler_result_tdata,
  input  logic                                  s_handler_result_tvalid,
  output logic                                  s_handler_result_tready,
  output logic [PORT_COUNT*OUT_WIDTH-1:0]       m_result_out_tdata,
  output logic [PORT_COUNT-1:0]                 m_result_out_tvalid,
  input  logic [PORT_COUNT-1:0]                 m_result_out_tready,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight_count,
  output logic                                  err_orphan
);

  localparam int PW = $clog2(PORT_COUNT);
  localparam int TW = $clog2(MAX_INFLIGHT);
  localparam int CW = $clog2(MAX_INFLIGHT+1);

  logic [PW-1:0]       ptr_q, ptr_d;
  logic                hvalid_q, hvalid_d;
  logic [IN_WIDTH-1:0] hdata_q, hdata_d;
  logic [PW-1:0]       tag_q [MAX_INFLIGHT];
  logic [PW-1:0]       tag_d [MAX_INFLIGHT];
  logic [TW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;

  // Requester-indexed views of the MSB-first port vectors
  logic [IN_WIDTH-1:0] req_data [PORT_COUNT];
  logic [PORT_COUNT-1:0] req_vld, req_rdy, out_rdy, out_vld;

  logic                grant_found;
  logic [PW-1:0]       grant_idx;
  logic [IN_WIDTH-1:0] grant_data;
  logic                can_issue, accept, pop, fifo_nonempty, sel_rdy;
  logic [PW-1:0]       head;

  assign head          = tag_q[rd_q];
  assign fifo_nonempty = (cnt_q != '0);

  for (genvar g = 0; g < PORT_COUNT; g++) begin : g_port
    assign req_data[g] = s_event_in_tdata[(PORT_COUNT-1-g)*IN_WIDTH +: IN_WIDTH];
    assign req_vld[g]  = s_event_in_tvalid[PORT_COUNT-1-g];
    assign out_rdy[g]  = m_result_out_tready[PORT_COUNT-1-g];
    assign s_event_in_tready[PORT_COUNT-1-g]   = req_rdy[g];
    assign m_result_out_tvalid[PORT_COUNT-1-g] = out_vld[g];
    assign m_result_out_tdata[(PORT_COUNT-1-g)*OUT_WIDTH +: OUT_WIDTH] =
      (fifo_nonempty && head == PW'(g)) ? s_handler_result_tdata : '0;
  end

  // Round-robin search: first pass from ptr upward, second pass wraps to 0
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      if (!grant_found && req_vld[i] && i >= int'(ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = PW'(i);
        grant_data  = req_data[i];
      end
    end
    for (int i = 0; i < PORT_COUNT; i++) begin
      if (!grant_found && req_vld[i]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(i);
        grant_data  = req_data[i];
      end
    end
  end

  assign can_issue = (!hvalid_q || m_handler_tready) && (cnt_q < CW'(MAX_INFLIGHT));
  // Reset is folded in so tready reads 0 while rst is held with valids high
  assign accept    = !rst && can_issue && grant_found;

  always_comb begin
    req_rdy = '0;
    out_vld = '0;
    sel_rdy = 1'b0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      req_rdy[i] = accept && (grant_idx == PW'(i));
      out_vld[i] = s_handler_result_tvalid && fifo_nonempty && (head == PW'(i));
      if (head == PW'(i)) sel_rdy = out_rdy[i];
    end
  end

  assign s_handler_result_tready = fifo_nonempty && sel_rdy;
  assign pop = s_handler_result_tvalid && s_handler_result_tready;

  always_comb begin
    ptr_d    = ptr_q;
    hvalid_d = hvalid_q;
    hdata_d  = hdata_q;
    tag_d    = tag_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    err_d    = err_q | (s_handler_result_tvalid & ~fifo_nonempty);
    if (accept) begin
      hvalid_d     = 1'b1;
      hdata_d      = grant_data;
      tag_d[wr_q]  = grant_idx;
      wr_d         = wr_q + TW'(1);
      ptr_d        = (grant_idx == PW'(PORT_COUNT-1)) ? '0 : grant_idx + PW'(1);
    end else if (hvalid_q && m_handler_tready) begin
      hvalid_d = 1'b0;
    end
    if (pop) rd_d = rd_q + TW'(1);
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      hvalid_q <= 1'b0;
      hdata_q  <= '0;
      tag_q    <= '{default: '0};
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      hvalid_q <= hvalid_d;
      hdata_q  <= hdata_d;
      tag_q    <= tag_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign m_handler_tdata  = hdata_q;
  assign m_handler_tvalid = hvalid_q;
  assign inflight_count   = cnt_q;
  assign err_orphan       = err_q;

endmodule
